i2s_fir_filter: RTL and testbench
=================================

Name: i2s_fir_filter

Overview:
- Stereo FIR filter stage directly downstream of the I2S input block.
- Consumes 32-bit packed audio words {left[31:16], right[15:0]} over an rts/rtr handshake.
- Filters each channel with a shared, time-multiplexed multiply-accumulate against programmable Q1.15 coefficients.
- Presents filtered packed words to the next stage (I2S output path) over an rts/rtr handshake.

Parameters:
- TAPS, 8, number of FIR taps per channel; power of two, 2..16.
- CW, 16, coefficient width (signed Q1.15).
- DW, 16, per-channel sample width (signed two's complement).

Ports:
- clk  input  1  master clock
- rst_n  input  1  reset
- i2si_data  input  32  packed input sample {L,R}
- i2si_rts  input  1  upstream has a sample
- i2si_rtr  output  1  filter ready to accept a sample
- filt_data  output  32  packed filtered sample {L,R}
- filt_rts  output  1  filtered sample valid
- filt_rtr  input  1  downstream ready
- rf_filt_en  input  1  filter enable
- rf_filt_bypass  input  1  1 = pass newest input unchanged, same latency
- rf_coef_wr  input  1  one-cycle coefficient write strobe
- rf_coef_addr  input  log2(TAPS)  tap index
- rf_coef_data  input  CW  coefficient value

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - i2si_rtr=0, filt_rts=0, filt_data=0.
  - Delay lines all 0, accumulator 0, state IDLE.
  - coef[0]=0x7FFF, all other coef=0 (near-identity response).
- Transfer rule: a transfer occurs in any cycle with rts & rtr both high, on either interface.
- FSM states: IDLE, MAC_L, MAC_R, OUT.
- IDLE:
  - i2si_rtr = rf_filt_en (combinational from state and enable).
  - rf_filt_en=0: both delay lines cleared to 0 each cycle.
  - On input transfer: shift L and R delay lines (newest at index 0), clear accumulator, tap counter=0, go to MAC_L.
- MAC_L:
  - Each cycle, acc += dly_L[k]*coef[k], then k++.
  - After TAPS cycles: latch the saturated left result, clear acc, k=0, go to MAC_R.
- MAC_R:
  - Same as MAC_L on the right channel.
  - After TAPS cycles: register filt_data, set filt_rts=1, go to OUT.
- OUT:
  - filt_rts and filt_data held stable until a transfer on filt_rtr.
  - On transfer: filt_rts=0 next cycle, go to IDLE.
  - i2si_rtr=0 throughout OUT (no input buffering; backpressure propagates upstream).
- Latency: filt_rts rises exactly 2*TAPS+1 cycles after the input transfer cycle (17 for TAPS=8). Maximum throughput is one sample per 2*TAPS+2 cycles.
- Arithmetic:
  - Signed DW x CW product, 32 bits.
  - Accumulator is 32+log2(TAPS) bits, signed.
  - Result = (acc + 2^14) >>> 15 (arithmetic shift, round-half-up).
  - Result is saturated to [-32768, 32767].
- Bypass: rf_filt_bypass=1 (sampled at input transfer) outputs the accepted input word unchanged, with the same FSM timing.
- Enable drop mid-sample: an in-flight sample completes and is delivered; enable is only re-evaluated in IDLE.
- Coefficient writes:
  - Take effect the cycle after rf_coef_wr.
  - A write during MAC_L/MAC_R may affect the in-flight sample; software writes only while rf_filt_en=0.
  - Simultaneous write and read of the same tap: the MAC uses the old value.
- Reset mid-operation returns every register to its reset value immediately; any partial sample is discarded.

Decomposition:
- Shared include file holds:
  - default TAPS/CW/DW;
  - the FSM state encodings;
  - the rounding constant and the saturation limits 0x7FFF/0x8000.
- One natural sub-module, fir_mac: registered signed multiply-accumulate with clear, accumulate enable, and saturating round output.

Test Plan:
- Reset coefficients, input word 0x03E8FC18 (L=1000, R=-1000) -> filt_data=0x03E8FC18, with filt_rts high exactly 17 cycles after the transfer.
- Set coef[0]=0, coef[1]=0x4000; send 0x10002000 then 0x00000000 -> outputs 0x00000000, then 0x08001000 (one-sample delay, half gain).
- All coef=0x7FFF; send 0x7FFF8000 eight times -> the eighth output is 0x7FFF8000 (positive and negative saturation).
- Hold filt_rtr=0 for 50 cycles after filt_rts -> filt_data stable, i2si_rtr=0, no input accepted. Release -> one transfer, back to IDLE, i2si_rtr=1 next cycle.
- Set rf_filt_bypass=1 with coef all 0, input 0x12345678 -> filt_data=0x12345678.
- Drop rf_filt_en during MAC_L -> the current sample is still delivered, then i2si_rtr stays 0 and the delay lines read 0. Assert rst_n=0 during MAC_R -> filt_rts=0 and coef[0]=0x7FFF immediately.

Source files
------------

// File: rtl/i2s_fir_filter_pkg.sv
// Shared constants for the stereo I2S FIR filter: default sizes, FSM encodings,
// rounding constant and 16-bit saturation limits.
package i2s_fir_filter_pkg;

    localparam int TAPS_DEF = 8;
    localparam int CW_DEF   = 16;
    localparam int DW_DEF   = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC_L = 2'd1;
    localparam logic [1:0] ST_MAC_R = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam int RND_SHIFT = 15;
    localparam int RND_CONST = 1 << 14;

    localparam logic [15:0] SAT_MAX  = 16'h7FFF;
    localparam logic [15:0] SAT_MIN  = 16'h8000;
    localparam logic [15:0] COEF_ONE = 16'h7FFF;

endpackage

// File: rtl/i2s_fir_filter_mac.sv
// Registered signed multiply-accumulate with clear and enable; the output is the
// rounded, saturated value of the sum including the current product.
module i2s_fir_filter_mac
    import i2s_fir_filter_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int CW   = CW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_sample,
    input  logic signed [CW-1:0] i_coef,
    output logic signed [DW-1:0] o_result
);

    localparam int PW    = DW + CW;
    localparam int ACC_W = PW + $clog2(TAPS);

    localparam logic signed [ACC_W-1:0] L_RND = ACC_W'(RND_CONST);
    localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'($signed(SAT_MAX));
    localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'($signed(SAT_MIN));

    function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + L_RND) >>> RND_SHIFT;
        if (r > L_MAX)
            return DW'(SAT_MAX);
        else if (r < L_MIN)
            return DW'(SAT_MIN);
        return DW'(r);
    endfunction

    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_add;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod     = i_sample * i_coef;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_add      = i_en ? w_prod_ext : '0;
    assign w_sum      = r_acc + w_add;
    // Result reflects the final tap in the same cycle it is accumulated.
    assign o_result   = round_sat(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else
            r_acc <= i_clr ? '0 : w_sum;
    end

endmodule

// File: rtl/i2s_fir_filter.sv
// Stereo FIR stage behind the I2S input: one shared MAC runs TAPS cycles on the
// left channel then TAPS cycles on the right, then holds the packed result.
module i2s_fir_filter
    import i2s_fir_filter_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int CW   = CW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*DW-1:0]         i2si_data,
    input  logic                    i2si_rts,
    output logic                    i2si_rtr,
    output logic [2*DW-1:0]         filt_data,
    output logic                    filt_rts,
    input  logic                    filt_rtr,
    input  logic                    rf_filt_en,
    input  logic                    rf_filt_bypass,
    input  logic                    rf_coef_wr,
    input  logic [$clog2(TAPS)-1:0] rf_coef_addr,
    input  logic [CW-1:0]           rf_coef_data
);

    localparam int              AW     = $clog2(TAPS);
    localparam logic [AW-1:0]   K_LAST = AW'(TAPS - 1);

    logic [1:0]           r_state;
    logic [AW-1:0]        r_k;
    logic                 r_live;
    logic signed [DW-1:0] r_dly_l [TAPS];
    logic signed [DW-1:0] r_dly_r [TAPS];
    logic signed [CW-1:0] r_coef  [TAPS];
    logic signed [DW-1:0] r_left;
    logic                 r_bypass;
    logic [2*DW-1:0]      r_filt_data;
    logic                 r_filt_rts;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_mac;
    logic                 w_last;
    logic                 w_clr;
    logic signed [DW-1:0] w_sample;
    logic signed [CW-1:0] w_coef;
    logic signed [DW-1:0] w_result;

    // r_live keeps the input closed while reset is asserted even if enable is high.
    assign i2si_rtr   = r_live & (r_state == ST_IDLE) & rf_filt_en;
    assign w_in_xfer  = i2si_rts & i2si_rtr;
    assign w_out_xfer = r_filt_rts & filt_rtr;
    assign w_mac      = (r_state == ST_MAC_L) | (r_state == ST_MAC_R);
    assign w_last     = (r_k == K_LAST);
    assign w_clr      = w_in_xfer | (w_mac & w_last);
    assign w_sample   = (r_state == ST_MAC_R) ? r_dly_r[r_k] : r_dly_l[r_k];
    assign w_coef     = r_coef[r_k];
    assign filt_data  = r_filt_data;
    assign filt_rts   = r_filt_rts;

    i2s_fir_filter_mac #(
        .TAPS (TAPS),
        .CW   (CW),
        .DW   (DW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_en     (w_mac),
        .i_sample (w_sample),
        .i_coef   (w_coef),
        .o_result (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++)
                r_coef[i] <= '0;
            r_coef[0] <= CW'(COEF_ONE);
        end else if (rf_coef_wr) begin
            r_coef[rf_coef_addr] <= rf_coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_dly_l[i] <= '0;
                r_dly_r[i] <= '0;
            end
        end else if (w_in_xfer) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                r_dly_l[i] <= r_dly_l[i-1];
                r_dly_r[i] <= r_dly_r[i-1];
            end
            r_dly_l[0] <= i2si_data[2*DW-1:DW];
            r_dly_r[0] <= i2si_data[DW-1:0];
        end else if ((r_state == ST_IDLE) && !rf_filt_en) begin
            for (int i = 0; i < TAPS; i++) begin
                r_dly_l[i] <= '0;
                r_dly_r[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_live      <= 1'b0;
            r_left      <= '0;
            r_bypass    <= 1'b0;
            r_filt_data <= '0;
            r_filt_rts  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        r_bypass <= rf_filt_bypass;
                        r_k      <= '0;
                        r_state  <= ST_MAC_L;
                    end
                end
                ST_MAC_L: begin
                    r_k <= w_last ? '0 : r_k + 1'b1;
                    if (w_last) begin
                        r_left  <= w_result;
                        r_state <= ST_MAC_R;
                    end
                end
                ST_MAC_R: begin
                    r_k <= w_last ? '0 : r_k + 1'b1;
                    if (w_last) begin
                        // Bypass still walks the MAC so latency is identical.
                        r_filt_data <= r_bypass ? {r_dly_l[0], r_dly_r[0]}
                                                : {r_left, w_result};
                        r_filt_rts  <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (w_out_xfer) begin
                        r_filt_rts <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_fir_filter.sv
// Directed bench for i2s_fir_filter with hand-computed Q1.15 results.
module tb_i2s_fir_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i2si_data;
    logic        i2si_rts;
    logic        i2si_rtr;
    logic [31:0] filt_data;
    logic        filt_rts;
    logic        filt_rtr;
    logic        rf_filt_en;
    logic        rf_filt_bypass;
    logic        rf_coef_wr;
    logic [2:0]  rf_coef_addr;
    logic [15:0] rf_coef_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2s_fir_filter #(.TAPS(8), .CW(16), .DW(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i2si_data      (i2si_data),
        .i2si_rts       (i2si_rts),
        .i2si_rtr       (i2si_rtr),
        .filt_data      (filt_data),
        .filt_rts       (filt_rts),
        .filt_rtr       (filt_rtr),
        .rf_filt_en     (rf_filt_en),
        .rf_filt_bypass (rf_filt_bypass),
        .rf_coef_wr     (rf_coef_wr),
        .rf_coef_addr   (rf_coef_addr),
        .rf_coef_data   (rf_coef_data)
    );

    // Offers a word and returns just after the clock edge that accepted it.
    task automatic push(input logic [31:0] w, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        i2si_data = w;
        i2si_rts  = 1'b1;
        n = 0;
        while (!i2si_rtr && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!i2si_rtr) begin
            ok = 1'b0;
            i2si_rts = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        i2si_rts = 1'b0;
    endtask

    // Counts clock edges until filt_rts is seen (16 edges = 17th cycle after transfer).
    task automatic wait_out(output logic [31:0] got, output int lat, output bit ok);
        lat = 0;
        while (!filt_rts && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok  = filt_rts;
        got = filt_data;
    endtask

    task automatic run_sample(input logic [31:0] w, output logic [31:0] got,
                              output int lat, output bit ok);
        push(w, ok);
        if (!ok) return;
        wait_out(got, lat, ok);
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        rf_coef_wr   = 1'b1;
        rf_coef_addr = a;
        rf_coef_data = d;
        @(negedge clk);
        rf_coef_wr   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i2si_data = '0; i2si_rts = 1'b0; filt_rtr = 1'b1;
        rf_filt_en = 1'b0; rf_filt_bypass = 1'b0; rf_coef_wr = 1'b0;
        rf_coef_addr = '0; rf_coef_data = '0;
        #12;
        total++; if (i2si_rtr !== 1'b0) begin bad++; $display("FAIL reset_rtr got=%b want=0", i2si_rtr); end
        total++; if (filt_rts !== 1'b0) begin bad++; $display("FAIL reset_rts got=%b want=0", filt_rts); end
        total++; if (filt_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", filt_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity;
        logic [31:0] got; int lat; bit ok;
        rf_filt_en = 1'b1;
        run_sample(32'h03E8FC18, got, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL ident_timeout got=0 want=1"); end
        total++; if (got !== 32'h03E8FC18) begin bad++; $display("FAIL ident_data got=%h want=03e8fc18", got); end
        total++; if (lat !== 16) begin bad++; $display("FAIL ident_latency edges=%0d want=16", lat); end
    endtask

    task automatic test_delay_half;
        logic [31:0] g1, g2; int lat; bit ok1, ok2;
        rf_filt_en = 1'b0;
        write_coef(3'd0, 16'h0000);
        write_coef(3'd1, 16'h4000);
        rf_filt_en = 1'b1;
        run_sample(32'h10002000, g1, lat, ok1);
        run_sample(32'h00000000, g2, lat, ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL delay_timeout got=0 want=1"); end
        total++; if (g1 !== 32'h00000000) begin bad++; $display("FAIL delay_first got=%h want=00000000", g1); end
        total++; if (g2 !== 32'h08001000) begin bad++; $display("FAIL delay_second got=%h want=08001000", g2); end
    endtask

    task automatic test_saturation;
        logic [31:0] got, first; int lat; bit ok; int nok;
        rf_filt_en = 1'b0;
        for (int i = 0; i < 8; i++) write_coef(3'(i), 16'h7FFF);
        rf_filt_en = 1'b1;
        nok = 0; first = '0; got = '0;
        for (int i = 0; i < 8; i++) begin
            run_sample(32'h7FFF8000, got, lat, ok);
            if (!ok) nok++;
            if (i == 0) first = got;
        end
        total++; if (nok != 0) begin bad++; $display("FAIL sat_timeout got=%0d want=0", nok); end
        // Single tap: 32767*32767 rounds to 32766, -32768*32767 rounds to -32767.
        total++; if (first !== 32'h7FFE8001) begin bad++; $display("FAIL sat_first got=%h want=7ffe8001", first); end
        total++; if (got !== 32'h7FFF8000) begin bad++; $display("FAIL sat_eighth got=%h want=7fff8000", got); end
    endtask

    task automatic test_backpressure;
        logic [31:0] got; int lat; bit ok; int e_data, e_rts, e_rtr;
        rf_filt_en = 1'b0;
        write_coef(3'd0, 16'h7FFF);
        for (int i = 1; i < 8; i++) write_coef(3'(i), 16'h0000);
        rf_filt_en = 1'b1;
        filt_rtr = 1'b0;
        push(32'h03E8FC18, ok);
        got = '0;
        if (ok) wait_out(got, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=0 want=1"); end
        total++; if (got !== 32'h03E8FC18) begin bad++; $display("FAIL bp_data got=%h want=03e8fc18", got); end
        e_data = 0; e_rts = 0; e_rtr = 0;
        @(negedge clk);
        i2si_data = 32'h55555555;
        i2si_rts  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (filt_data !== 32'h03E8FC18) e_data++;
            if (filt_rts !== 1'b1) e_rts++;
            if (i2si_rtr !== 1'b0) e_rtr++;
        end
        total++; if (e_data != 0) begin bad++; $display("FAIL bp_hold_data errors=%0d want=0", e_data); end
        total++; if (e_rts != 0) begin bad++; $display("FAIL bp_hold_rts errors=%0d want=0", e_rts); end
        total++; if (e_rtr != 0) begin bad++; $display("FAIL bp_hold_rtr errors=%0d want=0", e_rtr); end
        i2si_rts = 1'b0;
        filt_rtr = 1'b1;
        @(posedge clk);
        #1;
        total++; if (filt_rts !== 1'b0) begin bad++; $display("FAIL bp_release_rts got=%b want=0", filt_rts); end
        total++; if (i2si_rtr !== 1'b1) begin bad++; $display("FAIL bp_release_rtr got=%b want=1", i2si_rtr); end
    endtask

    task automatic test_bypass;
        logic [31:0] got; int lat; bit ok;
        rf_filt_en = 1'b0;
        write_coef(3'd0, 16'h0000);
        rf_filt_en = 1'b1;
        rf_filt_bypass = 1'b1;
        run_sample(32'h12345678, got, lat, ok);
        total++; if (!ok || got !== 32'h12345678) begin bad++; $display("FAIL bypass_data got=%h want=12345678", got); end
        total++; if (lat !== 16) begin bad++; $display("FAIL bypass_latency edges=%0d want=16", lat); end
        rf_filt_bypass = 1'b0;
        run_sample(32'h12345678, got, lat, ok);
        total++; if (!ok || got !== 32'h00000000) begin bad++; $display("FAIL nobypass_data got=%h want=00000000", got); end
    endtask

    task automatic test_enable_drop;
        logic [31:0] got; int lat; bit ok; int e_rtr;
        rf_filt_en = 1'b0;
        write_coef(3'd0, 16'h7FFF);
        write_coef(3'd1, 16'h7FFF);
        rf_filt_en = 1'b1;
        run_sample(32'h03E8FC18, got, lat, ok);
        total++; if (!ok || got !== 32'h03E8FC18) begin bad++; $display("FAIL en_first got=%h want=03e8fc18", got); end
        push(32'h00640064, ok);
        repeat (2) @(negedge clk);
        rf_filt_en = 1'b0;
        got = '0;
        if (ok) wait_out(got, lat, ok);
        // (100+1000)*32767 -> 1100, (100-1000)*32767 -> -900
        total++; if (!ok || got !== 32'h044CFC7C) begin bad++; $display("FAIL en_drop_data got=%h want=044cfc7c", got); end
        @(posedge clk);
        #1;
        e_rtr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i2si_rtr !== 1'b0 || filt_rts !== 1'b0) e_rtr++;
        end
        total++; if (e_rtr != 0) begin bad++; $display("FAIL en_off_idle errors=%0d want=0", e_rtr); end
        rf_filt_en = 1'b1;
        // Cleared history means tap 1 sees zero, not the previous sample.
        run_sample(32'h00640064, got, lat, ok);
        total++; if (!ok || got !== 32'h00640064) begin bad++; $display("FAIL en_cleared got=%h want=00640064", got); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] got; int lat; bit ok; int e_rts;
        rf_filt_en = 1'b1;
        push(32'h03E8FC18, ok);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (filt_rts !== 1'b0) begin bad++; $display("FAIL rstmid_rts got=%b want=0", filt_rts); end
        total++; if (filt_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=00000000", filt_data); end
        total++; if (i2si_rtr !== 1'b0) begin bad++; $display("FAIL rstmid_rtr got=%b want=0", i2si_rtr); end
        @(negedge clk);
        rst_n = 1'b1;
        e_rts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (filt_rts !== 1'b0) e_rts++;
        end
        total++; if (e_rts != 0) begin bad++; $display("FAIL rstmid_discard errors=%0d want=0", e_rts); end
        run_sample(32'h03E8FC18, got, lat, ok);
        total++; if (!ok || got !== 32'h03E8FC18) begin bad++; $display("FAIL rstmid_coef0 got=%h want=03e8fc18", got); end
        // coef[1] back to 0: a surviving 0x7FFF would give 044cfc7c.
        run_sample(32'h00640064, got, lat, ok);
        total++; if (!ok || got !== 32'h00640064) begin bad++; $display("FAIL rstmid_coef1 got=%h want=00640064", got); end
    endtask

    initial begin
        test_reset;
        test_identity;
        test_delay_half;
        test_saturation;
        test_backpressure;
        test_bypass;
        test_enable_drop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
